// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: memory aluop codes,
// FSM state encoding, chip/write enable levels, byte-lane select patterns
// and small op-classification helpers.
package mem_access_unit_pkg;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mau_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mau_size_t;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;  // bits 31:24 (big-endian byte 0)
  localparam logic [3:0] SEL_HI_HALF = 4'b1100;
  localparam logic [3:0] SEL_LO_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  function automatic mau_size_t op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB:       return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH:       return SZ_HALF;
      OP_LW, OP_SW, OP_LL, OP_SC: return SZ_WORD;
      default:                    return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW) || (op == OP_LL);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic is_signed_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane alignment for the data-memory port.
//   op         : memory aluop
//   addr_lo    : byte offset within the word
//   wdata      : right-justified store data
//   rdata      : raw word read from RAM
//   sel        : byte lane select
//   store_data : store data replicated across lanes
//   load_data  : selected lane, sign/zero-extended
//   adel/ades  : misaligned load / store
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        adel,
  output logic        ades
);

  logic       misalign;
  logic       sext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sel        = SEL_NONE;
    store_data = '0;
    load_data  = '0;
    misalign   = 1'b0;
    sext       = is_signed_load(op);
    byte_v     = '0;
    half_v     = '0;
    case (op_size(op))
      SZ_BYTE: begin
        sel        = SEL_BYTE0 >> addr_lo;
        store_data = {4{wdata[7:0]}};
        case (addr_lo)
          2'b00:   byte_v = rdata[31:24];
          2'b01:   byte_v = rdata[23:16];
          2'b10:   byte_v = rdata[15:8];
          default: byte_v = rdata[7:0];
        endcase
        load_data = {{24{sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        misalign   = addr_lo[0];
        sel        = addr_lo[1] ? SEL_LO_HALF : SEL_HI_HALF;
        store_data = {2{wdata[15:0]}};
        half_v     = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        load_data  = {{16{sext & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        misalign   = (addr_lo != 2'b00);
        sel        = SEL_WORD;
        store_data = wdata;
        load_data  = rdata;
      end
      default: ;
    endcase
  end

  assign adel = misalign & is_load(op);
  assign ades = misalign & is_store(op);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data RAM. Accepts one load/store from the
// pipeline, drives ce/we/addr/sel/data for WAIT_STATES+1 cycles, returns
// aligned/extended load data or SC status with a one-cycle done pulse, and
// keeps the LL/SC link bit.
//   clk, rst           : clock, synchronous active-high reset
//   req_i/aluop_i/...  : request from pipeline (sampled in IDLE)
//   llbit_clr_i        : clear link bit
//   stall_req_o        : hold pipeline while an access is in flight
//   done_o, wreg_o, wd_o, rdata_o, adel_o, ades_o : completion (valid in DONE)
//   mem_*              : RAM port
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WAIT_STATES      = 0,
  parameter bit          LLBIT_ADDR_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        llbit_clr_i,
  output logic        stall_req_o,
  output logic        done_o,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  mau_state_t state_q, state_d;
  logic [3:0]  cnt_q;
  logic [7:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  wd_q;
  logic        sc_ok_q;
  logic        wreg_q;
  logic        adel_q;
  logic        ades_q;
  logic [31:0] rdata_q;
  logic        llbit_q;
  logic [31:0] llbit_addr_q;

  logic [7:0]  al_op;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_wdata;
  logic [3:0]  al_sel;
  logic [31:0] al_store;
  logic [31:0] al_load;
  logic        al_adel;
  logic        al_ades;

  logic in_idle, in_access, in_done, last_access, sc_ok_now, do_write;

  assign in_idle     = (state_q == ST_IDLE);
  assign in_access   = (state_q == ST_ACCESS);
  assign in_done     = (state_q == ST_DONE);
  assign last_access = in_access & (cnt_q == 4'(WAIT_STATES));

  // One aligner serves both phases: live request fields in IDLE (for the
  // misalign decision) and latched fields during ACCESS.
  assign al_op      = in_idle ? aluop_i      : op_q;
  assign al_addr_lo = in_idle ? addr_i[1:0]  : addr_q[1:0];
  assign al_wdata   = in_idle ? wdata_i      : wdata_q;

  mem_lane_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .wdata      (al_wdata),
    .rdata      (mem_data_i),
    .sel        (al_sel),
    .store_data (al_store),
    .load_data  (al_load),
    .adel       (al_adel),
    .ades       (al_ades)
  );

  assign sc_ok_now = llbit_q & (!LLBIT_ADDR_CHECK || (addr_i == llbit_addr_q));
  assign do_write  = last_access & is_store(op_q) & ((op_q != OP_SC) | sc_ok_q);

  always_comb begin
    state_d     = state_q;
    stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          stall_req_o = 1'b1;
          state_d     = (al_adel | al_ades) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall_req_o = 1'b1;
        if (last_access) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Enables are gated by rst so nothing is committed on a reset edge.
  assign mem_ce_o   = (in_access & !rst) ? CHIP_ENABLE  : CHIP_DISABLE;
  assign mem_we_o   = (do_write  & !rst) ? WRITE_ENABLE : WRITE_DISABLE;
  assign mem_addr_o = in_access ? {addr_q[31:2], 2'b00} : '0;
  assign mem_sel_o  = in_access ? al_sel   : SEL_NONE;
  assign mem_data_o = in_access ? al_store : '0;

  assign done_o  = in_done;
  assign wreg_o  = in_done & wreg_q;
  assign wd_o    = in_done ? wd_q    : '0;
  assign rdata_o = in_done ? rdata_q : '0;
  assign adel_o  = in_done & adel_q;
  assign ades_o  = in_done & ades_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wd_q         <= '0;
      sc_ok_q      <= 1'b0;
      wreg_q       <= 1'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      rdata_q      <= '0;
      llbit_q      <= 1'b0;
      llbit_addr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            op_q    <= aluop_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wd_q    <= wd_i;
            cnt_q   <= '0;
            sc_ok_q <= (aluop_i == OP_SC) & sc_ok_now;
            adel_q  <= al_adel;
            ades_q  <= al_ades;
            rdata_q <= '0;
            wreg_q  <= !(al_adel | al_ades) & (is_load(aluop_i) | (aluop_i == OP_SC));
          end
        end
        ST_ACCESS: begin
          if (!last_access) begin
            cnt_q <= cnt_q + 4'd1;
          end else if (is_load(op_q)) begin
            rdata_q <= al_load;
          end else if (op_q == OP_SC) begin
            rdata_q <= {31'b0, sc_ok_q};
          end
        end
        ST_DONE: begin
          if (op_q == OP_LL && !adel_q) begin
            llbit_q      <= 1'b1;
            llbit_addr_q <= addr_q;
          end else if (op_q == OP_SC && sc_ok_q) begin
            llbit_q <= 1'b0;
          end
        end
        default: ;
      endcase
      // Placed last so an external clear overrides an LL completing now.
      if (llbit_clr_i) llbit_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req3 = 1'b0;
  logic [7:0]  aluop = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  wd = '0;
  logic        llclr = 1'b0;

  logic stall0, done0, wreg0, adel0, ades0, ce0, we0;
  logic [4:0] wd0; logic [31:0] rdata0, maddr0, mdata0, mdi0; logic [3:0] msel0;
  logic stall3, done3, wreg3, adel3, ades3, ce3, we3;
  logic [4:0] wd3; logic [31:0] rdata3, maddr3, mdata3; logic [3:0] msel3;
  logic [31:0] mdi3;

  logic [31:0] ram [0:255];
  int n_chk = 0;
  int n_fail = 0;
  logic use_d3 = 1'b0;

  always #5 clk = ~clk;

  assign mdi0 = ram[maddr0[9:2]];
  assign mdi3 = 32'hCAFEBABE;

  always @(posedge clk) begin
    if (ce0 && we0) begin
      if (msel0[3]) ram[maddr0[9:2]][31:24] <= mdata0[31:24];
      if (msel0[2]) ram[maddr0[9:2]][23:16] <= mdata0[23:16];
      if (msel0[1]) ram[maddr0[9:2]][15:8]  <= mdata0[15:8];
      if (msel0[0]) ram[maddr0[9:2]][7:0]   <= mdata0[7:0];
    end
  end

  mem_access_unit #(.WAIT_STATES(0), .LLBIT_ADDR_CHECK(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .aluop_i(aluop), .addr_i(addr),
    .wdata_i(wdata), .wd_i(wd), .llbit_clr_i(llclr), .stall_req_o(stall0),
    .done_o(done0), .wreg_o(wreg0), .wd_o(wd0), .rdata_o(rdata0),
    .adel_o(adel0), .ades_o(ades0), .mem_ce_o(ce0), .mem_we_o(we0),
    .mem_addr_o(maddr0), .mem_sel_o(msel0), .mem_data_o(mdata0), .mem_data_i(mdi0));

  mem_access_unit #(.WAIT_STATES(3), .LLBIT_ADDR_CHECK(1'b1)) dut3 (
    .clk(clk), .rst(rst), .req_i(req3), .aluop_i(aluop), .addr_i(addr),
    .wdata_i(wdata), .wd_i(wd), .llbit_clr_i(llclr), .stall_req_o(stall3),
    .done_o(done3), .wreg_o(wreg3), .wd_o(wd3), .rdata_o(rdata3),
    .adel_o(adel3), .ades_o(ades3), .mem_ce_o(ce3), .mem_we_o(we3),
    .mem_addr_o(maddr3), .mem_sel_o(msel3), .mem_data_o(mdata3), .mem_data_i(mdi3));

  logic        o_stall, o_ce, o_we, o_done, o_wreg, o_adel, o_ades;
  logic [4:0]  o_wd;
  logic [31:0] o_rdata, o_maddr, o_mdata;
  logic [3:0]  o_msel;
  assign o_stall = use_d3 ? stall3 : stall0;
  assign o_ce    = use_d3 ? ce3    : ce0;
  assign o_we    = use_d3 ? we3    : we0;
  assign o_done  = use_d3 ? done3  : done0;
  assign o_wreg  = use_d3 ? wreg3  : wreg0;
  assign o_adel  = use_d3 ? adel3  : adel0;
  assign o_ades  = use_d3 ? ades3  : ades0;
  assign o_wd    = use_d3 ? wd3    : wd0;
  assign o_rdata = use_d3 ? rdata3 : rdata0;
  assign o_maddr = use_d3 ? maddr3 : maddr0;
  assign o_mdata = use_d3 ? mdata3 : mdata0;
  assign o_msel  = use_d3 ? msel3  : msel0;

  // Issues one request and observes it until done_o (bounded). lat is the
  // done cycle relative to the request cycle, -1 if done never came.
  typedef struct {
    int lat; int nstall; int nce; int nwe;
    logic [31:0] waddr; logic [3:0] wsel; logic [31:0] wdat;
    logic [31:0] rd; logic wreg; logic [4:0] wdo; logic adel; logic ades;
  } obs_t;

  task automatic run_txn(input logic d3, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] w, output obs_t r);
    r = '{lat: -1, nstall: 0, nce: 0, nwe: 0, waddr: '0, wsel: '0, wdat: '0,
          rd: '0, wreg: 1'b0, wdo: '0, adel: 1'b0, ades: 1'b0};
    @(negedge clk);
    use_d3 = d3;
    aluop = op; addr = a; wdata = d; wd = w;
    if (d3) req3 = 1'b1; else req0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (o_stall) r.nstall++;
      if (o_ce) r.nce++;
      if (o_we) begin r.nwe++; r.waddr = o_maddr; r.wsel = o_msel; r.wdat = o_mdata; end
      if (o_done) begin
        r.lat = i; r.rd = o_rdata; r.wreg = o_wreg; r.wdo = o_wd;
        r.adel = o_adel; r.ades = o_ades;
        break;
      end
      @(negedge clk);
      req0 = 1'b0; req3 = 1'b0;
    end
    req0 = 1'b0; req3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({stall0, done0, wreg0, wd0, rdata0, adel0, ades0, ce0, we0, maddr0, msel0, mdata0} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_dut0: got nonzero output(s) rdata=%h addr=%h sel=%b", rdata0, maddr0, msel0);
    end
    n_chk++;
    if ({stall3, done3, ce3, we3, rdata3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_dut3: got stall=%b done=%b ce=%b we=%b expected all 0", stall3, done3, ce3, we3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte();
    obs_t r;
    run_txn(1'b0, OP_SB, 32'h41, 32'hA5, 5'd0, r);
    n_chk++; if (r.lat !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", r.lat); end
    n_chk++; if (r.nwe !== 1 || r.waddr !== 32'h40) begin n_fail++; $display("FAIL sb_addr: nwe=%0d addr=%h expected 1 / 00000040", r.nwe, r.waddr); end
    n_chk++; if (r.wsel !== 4'b0100) begin n_fail++; $display("FAIL sb_sel: got %b expected 0100", r.wsel); end
    n_chk++; if (r.wdat !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_data: got %h expected a5a5a5a5", r.wdat); end
    n_chk++; if (r.wreg !== 1'b0) begin n_fail++; $display("FAIL sb_wreg: got %b expected 0", r.wreg); end
    run_txn(1'b0, OP_LB, 32'h41, 32'h0, 5'd9, r);
    n_chk++; if (r.rd !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffffa5", r.rd); end
    n_chk++; if (r.wreg !== 1'b1 || r.wdo !== 5'd9) begin n_fail++; $display("FAIL lb_wreg_wd: got %b/%0d expected 1/9", r.wreg, r.wdo); end
    n_chk++; if (r.nwe !== 0 || r.nce !== 1) begin n_fail++; $display("FAIL lb_ce_we: nce=%0d nwe=%0d expected 1/0", r.nce, r.nwe); end
    run_txn(1'b0, OP_LBU, 32'h41, 32'h0, 5'd3, r);
    n_chk++; if (r.rd !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_zext: got %h expected 000000a5", r.rd); end
  endtask

  task automatic test_half();
    obs_t r;
    run_txn(1'b0, OP_SW, 32'h80, 32'h12345678, 5'd0, r);
    n_chk++; if (r.wsel !== 4'b1111 || r.wdat !== 32'h12345678) begin n_fail++; $display("FAIL sw_sel_data: got %b/%h expected 1111/12345678", r.wsel, r.wdat); end
    run_txn(1'b0, OP_LH, 32'h82, 32'h0, 5'd4, r);
    n_chk++; if (r.rd !== 32'h00005678) begin n_fail++; $display("FAIL lh_lo: got %h expected 00005678", r.rd); end
    run_txn(1'b0, OP_LH, 32'h80, 32'h0, 5'd4, r);
    n_chk++; if (r.rd !== 32'h00001234) begin n_fail++; $display("FAIL lh_hi: got %h expected 00001234", r.rd); end
    run_txn(1'b0, OP_LB, 32'h83, 32'h0, 5'd4, r);
    n_chk++; if (r.rd !== 32'h00000078) begin n_fail++; $display("FAIL lb_lane3: got %h expected 00000078", r.rd); end
    run_txn(1'b0, OP_SH, 32'h86, 32'hBEEF, 5'd0, r);
    n_chk++; if (r.wsel !== 4'b0011 || r.wdat !== 32'hBEEFBEEF || r.waddr !== 32'h84) begin
      n_fail++; $display("FAIL sh_lanes: got sel=%b data=%h addr=%h expected 0011/beefbeef/00000084", r.wsel, r.wdat, r.waddr); end
    run_txn(1'b0, OP_LH, 32'h86, 32'h0, 5'd4, r);
    n_chk++; if (r.rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_sext: got %h expected ffffbeef", r.rd); end
    run_txn(1'b0, OP_LHU, 32'h86, 32'h0, 5'd4, r);
    n_chk++; if (r.rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu_zext: got %h expected 0000beef", r.rd); end
  endtask

  task automatic test_misalign();
    obs_t r;
    run_txn(1'b0, OP_LH, 32'h81, 32'h0, 5'd6, r);
    n_chk++; if (r.lat !== 1) begin n_fail++; $display("FAIL lh_mis_latency: got %0d expected 1", r.lat); end
    n_chk++; if (r.adel !== 1'b1 || r.ades !== 1'b0 || r.wreg !== 1'b0) begin
      n_fail++; $display("FAIL lh_mis_flags: adel=%b ades=%b wreg=%b expected 1/0/0", r.adel, r.ades, r.wreg); end
    n_chk++; if (r.nce !== 0) begin n_fail++; $display("FAIL lh_mis_ce: got %0d ce cycles expected 0", r.nce); end
    run_txn(1'b0, OP_SW, 32'h82, 32'hFFFFFFFF, 5'd0, r);
    n_chk++; if (r.ades !== 1'b1 || r.adel !== 1'b0 || r.nce !== 0 || r.lat !== 1) begin
      n_fail++; $display("FAIL sw_mis: ades=%b adel=%b nce=%0d lat=%0d expected 1/0/0/1", r.ades, r.adel, r.nce, r.lat); end
  endtask

  task automatic test_wait_states();
    obs_t r;
    run_txn(1'b1, OP_LW, 32'h10, 32'h0, 5'd7, r);
    n_chk++; if (r.nstall !== 5) begin n_fail++; $display("FAIL ws3_stall: got %0d cycles expected 5", r.nstall); end
    n_chk++; if (r.lat !== 5) begin n_fail++; $display("FAIL ws3_latency: got %0d expected 5", r.lat); end
    n_chk++; if (r.nce !== 4 || r.nwe !== 0) begin n_fail++; $display("FAIL ws3_ce_we: nce=%0d nwe=%0d expected 4/0", r.nce, r.nwe); end
    n_chk++; if (r.rd !== 32'hCAFEBABE) begin n_fail++; $display("FAIL ws3_rdata: got %h expected cafebabe", r.rd); end
  endtask

  task automatic test_llsc();
    obs_t r;
    run_txn(1'b0, OP_SW, 32'h100, 32'h55AA0000, 5'd0, r);
    run_txn(1'b0, OP_LL, 32'h100, 32'h0, 5'd2, r);
    n_chk++; if (r.rd !== 32'h55AA0000 || r.wreg !== 1'b1) begin n_fail++; $display("FAIL ll_load: got %h/%b expected 55aa0000/1", r.rd, r.wreg); end
    run_txn(1'b0, OP_SC, 32'h100, 32'h7, 5'd2, r);
    n_chk++; if (r.nwe !== 1 || r.rd !== 32'h1 || r.wreg !== 1'b1) begin
      n_fail++; $display("FAIL sc_ok: nwe=%0d rdata=%h wreg=%b expected 1/00000001/1", r.nwe, r.rd, r.wreg); end
    n_chk++; if (ram[64] !== 32'h7) begin n_fail++; $display("FAIL sc_ok_mem: got %h expected 00000007", ram[64]); end
    run_txn(1'b0, OP_SC, 32'h100, 32'h9, 5'd2, r);
    n_chk++; if (r.nwe !== 0 || r.nce !== 1 || r.rd !== 32'h0) begin
      n_fail++; $display("FAIL sc_again: nwe=%0d nce=%0d rdata=%h expected 0/1/00000000", r.nwe, r.nce, r.rd); end
    n_chk++; if (ram[64] !== 32'h7) begin n_fail++; $display("FAIL sc_again_mem: got %h expected 00000007", ram[64]); end
    run_txn(1'b0, OP_LL, 32'h100, 32'h0, 5'd2, r);
    @(negedge clk); llclr = 1'b1;
    @(negedge clk); llclr = 1'b0;
    run_txn(1'b0, OP_SC, 32'h100, 32'h5, 5'd2, r);
    n_chk++; if (r.nwe !== 0 || r.rd !== 32'h0) begin n_fail++; $display("FAIL sc_after_clr: nwe=%0d rdata=%h expected 0/00000000", r.nwe, r.rd); end
    run_txn(1'b0, OP_LL, 32'h100, 32'h0, 5'd2, r);
    run_txn(1'b0, OP_SC, 32'h104, 32'h5, 5'd2, r);
    n_chk++; if (r.nwe !== 0 || r.rd !== 32'h0) begin n_fail++; $display("FAIL sc_addr_mismatch: nwe=%0d rdata=%h expected 0/00000000", r.nwe, r.rd); end
  endtask

  task automatic test_reset_mid();
    obs_t r;
    logic saw_done;
    run_txn(1'b0, OP_SW, 32'hC0, 32'h11111111, 5'd0, r);
    @(negedge clk);
    use_d3 = 1'b0;
    aluop = OP_SW; addr = 32'hC0; wdata = 32'hDEADBEEF; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; rst = 1'b1;
    #1;
    n_chk++; if (we0 !== 1'b0 || ce0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gate: we=%b ce=%b expected 0/0", we0, ce0); end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (done0) saw_done = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got done pulse expected none"); end
    run_txn(1'b0, OP_LW, 32'hC0, 32'h0, 5'd1, r);
    n_chk++; if (r.rd !== 32'h11111111 || r.lat !== 2) begin
      n_fail++; $display("FAIL rst_mid_mem: got %h lat=%0d expected 11111111 lat=2", r.rd, r.lat); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_wait_states();
    test_llsc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
